// File: rtl/alu_op_sequencer.sv
// Sequential valid/ready front end for the combinational ALU with result/flag capture.
// Define ALU_SEQ_MUL_EN to build the shift-add multiply (opcode 4'b1110); otherwise it is illegal.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  input  logic [WIDTH-1:0] alu_g,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_o,
  input  logic             alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_alu_a, w_alu_a_nxt;
  logic [WIDTH-1:0] r_alu_b, w_alu_b_nxt;
  logic [3:0]       r_alu_s, w_alu_s_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [3:0]       r_flags, w_flags_nxt;
  logic             r_err, w_err_nxt;
  logic             r_in_ready, r_out_valid;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CW     = $clog2(WIDTH) + 1;
  localparam logic [3:0]  OP_MUL = 4'b1110;
  localparam logic [3:0]  S_ADD  = 4'b0010;

  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_csticky, w_csticky_nxt;
  logic [WIDTH-1:0] w_acc_step;
  logic             w_csticky_step;

  // Accumulate only when the current multiplier bit is set.
  assign w_acc_step     = r_mplier[0] ? alu_g : r_acc;
  assign w_csticky_step = r_csticky | (r_mplier[0] & alu_c);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_alu_a_nxt  = '0;
    w_alu_b_nxt  = '0;
    w_alu_s_nxt  = '0;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    w_err_nxt    = r_err;
`ifdef ALU_SEQ_MUL_EN
    w_acc_nxt     = r_acc;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_cnt_nxt     = r_cnt;
    w_csticky_nxt = r_csticky;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          if (in_op == OP_MUL) begin
            w_state_nxt   = S_MUL;
            w_acc_nxt     = '0;
            w_mcand_nxt   = in_a;
            w_mplier_nxt  = in_b;
            w_cnt_nxt     = '0;
            w_csticky_nxt = 1'b0;
            w_alu_b_nxt   = in_a;
            w_alu_s_nxt   = S_ADD;
          end else
`endif
          if (in_op[3:1] == 3'b111) begin
            w_state_nxt  = S_DONE;
            w_result_nxt = '0;
            w_flags_nxt  = '0;
            w_err_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_EXEC;
            w_alu_a_nxt = in_a;
            w_alu_b_nxt = in_b;
            w_alu_s_nxt = in_op;
          end
        end
      end
      S_EXEC: begin
        w_state_nxt  = S_DONE;
        w_result_nxt = alu_g;
        w_flags_nxt  = {alu_z, alu_n, alu_o, alu_c};
        w_err_nxt    = 1'b0;
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        w_acc_nxt     = w_acc_step;
        w_csticky_nxt = w_csticky_step;
        w_mcand_nxt   = r_mcand << 1;
        w_mplier_nxt  = r_mplier >> 1;
        w_cnt_nxt     = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt  = S_DONE;
          w_result_nxt = w_acc_step;
          w_flags_nxt  = {(w_acc_step == '0), w_acc_step[WIDTH-1], 1'b0, w_csticky_step};
          w_err_nxt    = 1'b0;
        end else begin
          w_alu_a_nxt = w_acc_step;
          w_alu_b_nxt = r_mcand << 1;
          w_alu_s_nxt = S_ADD;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ALU drive and handshake outputs are registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_s     <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_csticky   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_alu_s     <= w_alu_s_nxt;
      r_result    <= w_result_nxt;
      r_flags     <= w_flags_nxt;
      r_err       <= w_err_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
`ifdef ALU_SEQ_MUL_EN
      r_acc       <= w_acc_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_cnt       <= w_cnt_nxt;
      r_csticky   <= w_csticky_nxt;
`endif
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_s      = r_alu_s;
  assign out_result = r_result;
  assign out_flags  = r_flags;
  assign out_err    = r_err;

endmodule
